// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch PC redirect controller.
package pc_ctrl_pkg;

    localparam int unsigned PC_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // StWaitDs: branch target saved, delay slot still to be fetched.
    // StPending: redirect target saved, owed to IF together with a flush.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitDs  = 2'd1,
        StPending = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority selection of the next fetch PC, write strobe, IF flush
// and redirect-controller next state.
module pc_next_sel
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned PC_STEP = 4
) (
    input  logic            rst,
    input  pc_state_e       state,
    input  logic [PC_W-1:0] pc_q,
    input  logic [PC_W-1:0] saved_tgt,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            ds_fetched,
    input  logic            exc_valid,
    input  logic [PC_W-1:0] exc_vector,
    input  logic            eret_valid,
    input  logic [PC_W-1:0] epc,
    output logic [PC_W-1:0] npc,
    output logic            pc_wr,
    output logic            flush_if,
    output pc_state_e       state_next,
    output logic            save_en,
    output logic [PC_W-1:0] save_val
);

    logic            advance;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] trap_tgt;

    assign advance  = fetch_ready & ~stall;
    assign seq_pc   = pc_q + PC_W'(PC_STEP);
    assign trap_tgt = exc_valid ? exc_vector : epc;

    // Priority: exception > ERET > held redirect > new branch > sequential.
    always_comb begin
        npc        = seq_pc;
        pc_wr      = 1'b0;
        flush_if   = 1'b0;
        state_next = state;
        save_en    = 1'b0;
        save_val   = '0;

        if (exc_valid || eret_valid) begin
            // Traps ignore stall and overwrite any saved branch target.
            if (fetch_ready) begin
                npc        = trap_tgt;
                pc_wr      = 1'b1;
                flush_if   = 1'b1;
                state_next = StIdle;
            end else begin
                save_en    = 1'b1;
                save_val   = trap_tgt;
                state_next = StPending;
            end
        end else begin
            case (state)
                StIdle: begin
                    if (branch_taken && !ds_fetched) begin
                        // Sequential advance this cycle fetches the delay slot.
                        save_en    = 1'b1;
                        save_val   = branch_target;
                        state_next = StWaitDs;
                        pc_wr      = advance;
                    end else if (branch_taken) begin
                        if (fetch_ready) begin
                            npc      = branch_target;
                            pc_wr    = 1'b1;
                            flush_if = 1'b1;
                        end else begin
                            save_en    = 1'b1;
                            save_val   = branch_target;
                            state_next = StPending;
                        end
                    end else begin
                        pc_wr = advance;
                    end
                end
                StWaitDs: begin
                    // Delay slot is already in flight, so no flush.
                    if (advance) begin
                        npc        = saved_tgt;
                        pc_wr      = 1'b1;
                        state_next = StIdle;
                    end
                end
                StPending: begin
                    if (fetch_ready) begin
                        npc        = saved_tgt;
                        pc_wr      = 1'b1;
                        flush_if   = 1'b1;
                        state_next = StIdle;
                    end
                end
                default: begin
                    state_next = StIdle;
                end
            endcase
        end

        if (rst) begin
            pc_wr    = 1'b0;
            flush_if = 1'b0;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: owns the architectural fetch PC, the redirect state and the
// saved redirect target; next-value selection lives in pc_next_sel.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            ds_fetched,
    input  logic            exc_valid,
    input  logic [PC_W-1:0] exc_vector,
    input  logic            eret_valid,
    input  logic [PC_W-1:0] epc,
    output logic [PC_W-1:0] pc_q,
    output logic [PC_W-1:0] npc,
    output logic            pc_wr,
    output logic            flush_if
);

    pc_state_e       state_q;
    pc_state_e       state_d;
    logic [PC_W-1:0] saved_q;
    logic            save_en;
    logic [PC_W-1:0] save_val;

    pc_next_sel #(
        .PC_STEP(PC_STEP)
    ) u_sel (
        .rst          (rst),
        .state        (state_q),
        .pc_q         (pc_q),
        .saved_tgt    (saved_q),
        .fetch_ready  (fetch_ready),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .ds_fetched   (ds_fetched),
        .exc_valid    (exc_valid),
        .exc_vector   (exc_vector),
        .eret_valid   (eret_valid),
        .epc          (epc),
        .npc          (npc),
        .pc_wr        (pc_wr),
        .flush_if     (flush_if),
        .state_next   (state_d),
        .save_en      (save_en),
        .save_val     (save_val)
    );

    // PC, redirect state and saved target registers; reset drops any owed redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= StIdle;
            saved_q <= '0;
        end else begin
            if (pc_wr) begin
                pc_q <= npc;
            end
            state_q <= state_d;
            if (save_en) begin
                saved_q <= save_val;
            end
        end
    end

endmodule
